sysid_boot_checker: RTL and testbench
=====================================

Name: sysid_boot_checker

Overview:
- Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its readdata.
- After reset (or on request) it reads word 0 (system ID) and word 1 (build timestamp) and compares each against its expected parameter value.
- It holds the soft-CPU in reset until the check passes, or until software/board straps bypass it.
- Pass/fail, timeout and the captured words are exported for LEDs and debug CSRs.

Parameters:
- EXPECTED_ID, 32'hDEADBEEF, value required at address 0.
- EXPECTED_TS, 32'h5B92B311, value required at address 1.
- CHECK_TS, 1, 0 = timestamp mismatch is reported in fail_ts but does not affect pass.
- READ_LATENCY, 0, cycles from accepted read to valid readdata (0..3).
- TIMEOUT_CYCLES, 255, max cycles waiting per transaction (waitrequest + latency); 8-bit minimum counter width, sized by clog2.
- AUTO_START, 1, start a check automatically on reset release.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle recheck request; ignored while busy.
- bypass  in  1  forces cpu_reset low regardless of result.
- av_address  out  1  0 = ID, 1 = timestamp.
- av_read  out  1  read strobe.
- av_waitrequest  in  1  slave stall (tie 0 for the zero-wait ID slave).
- av_readdata  in  32  slave read data.
- busy  out  1  check in progress.
- done  out  1  sticky; a check has completed (pass, fail or timeout).
- pass  out  1  id_ok && (ts_ok || !CHECK_TS) && !timeout.
- fail_id  out  1  ID mismatch.
- fail_ts  out  1  timestamp mismatch.
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES.
- id_q  out  32  captured ID word.
- ts_q  out  32  captured timestamp word.
- cpu_reset  out  1  high until pass, low when pass || bypass.

Behaviour:
- Reset values: all outputs 0 except cpu_reset = 1; state = IDLE; counters = 0.
- All outputs are registered; cpu_reset = !(pass_r || bypass), with the bypass path combinational.
- FSM states: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CMP, DONE.
- IDLE:
  - First cycle after reset with AUTO_START = 1 → RD_ID.
  - Otherwise waits for start.
- RD_ID:
  - av_read = 1, av_address = 0; held stable while av_waitrequest = 1.
  - On acceptance (av_read && !av_waitrequest):
    - READ_LATENCY = 0: capture av_readdata into id_q that cycle, → RD_TS.
    - READ_LATENCY > 0: → WAIT_ID.
- WAIT_ID: av_read = 0; capture id_q exactly READ_LATENCY cycles after acceptance, → RD_TS.
- RD_TS / WAIT_TS: same as RD_ID / WAIT_ID with av_address = 1, capturing ts_q; then → CMP.
- CMP:
  - Registers fail_id = (id_q != EXPECTED_ID) and fail_ts = (ts_q != EXPECTED_TS).
  - Registers pass; sets done; → DONE.
- DONE: busy = 0; start → RD_ID, clearing pass, fail_*, timeout and done in the same edge; cpu_reset reasserts unless bypass.
- Timeout counter:
  - Clears on entry to each RD_* state and increments every cycle in RD_* / WAIT_*.
  - On reaching TIMEOUT_CYCLES: drop av_read, set timeout = 1, pass = 0, done = 1, → DONE. The captured words stay as last written.
- Cycle timing, zero latency and no wait states: done and pass are high after the 4th rising edge following reset release (IDLE, RD_ID, RD_TS, CMP).
- busy = 1 in all states except IDLE and DONE.
- start during busy: ignored, no queuing.
- Asynchronous reset mid-transaction:
  - av_read drops immediately.
  - Captured words and flags clear.
  - With AUTO_START = 1 the check restarts.
- bypass may change at any time; it never alters FSM or flags.

Decomposition:
- Package sysid_pkg holds:
  - ADDR_SYSID_ID = 1'b0 and ADDR_SYSID_TS = 1'b1.
  - Default EXPECTED_ID/TS constants.
  - FSM state enum typedef, 3-bit encoding.
- Natural sub-module: sysid_av_read_port.
  - Issues one read, honours waitrequest and READ_LATENCY, runs the timeout counter.
  - Returns data_valid/data/timed_out to the checker FSM.

Test Plan:
- Zero-wait slave returning 0xDEADBEEF / 0x5B92B311, AUTO_START = 1 → done = pass = 1 and cpu_reset = 0 on the 4th edge after reset release; av_address sequence 0, 1.
- ID slave returns 0xDEADBEEE → fail_id = 1, pass = 0, cpu_reset = 1; id_q = 0xDEADBEEE. Then assert bypass → cpu_reset = 0, flags unchanged.
- Timestamp 0x00000000 with CHECK_TS = 1 → fail_ts = 1, pass = 0. Same with CHECK_TS = 0 → fail_ts = 1, pass = 1.
- waitrequest held high 300 cycles, TIMEOUT_CYCLES = 255 → timeout = 1, done = 1, av_read low, pass = 0. Release waitrequest, pulse start → pass = 1 and timeout cleared.
- READ_LATENCY = 2, waitrequest high 3 cycles on the ID read → id_q captured 2 cycles after acceptance, av_read low during WAIT_ID, pass = 1. A start pulse during busy has no effect.
- Assert reset while in RD_TS → av_read, busy and flags go to 0 immediately and cpu_reset = 1. After release the check reruns and passes.

Source files
------------

// File: rtl/sysid_boot_checker_pkg.sv
// Shared constants and FSM encoding for the system-ID boot checker.
package sysid_pkg;

  localparam logic ADDR_SYSID_ID = 1'b0;
  localparam logic ADDR_SYSID_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'hDEADBEEF;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5B92B311;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the system-ID slave.
interface sysid_boot_checker_if;
  logic        av_address;
  logic        av_read;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (output av_address, av_read, input av_waitrequest, av_readdata);
  modport slave  (input av_address, av_read, output av_waitrequest, av_readdata);
endinterface

// File: rtl/sysid_boot_checker_av_read_port.sv
// Single-read Avalon-MM engine: issues one read on launch, waits out waitrequest
// and the fixed read latency, and flags a transaction that runs too long.
module sysid_av_read_port #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        launch,
  input  logic        launch_addr,
  sysid_boot_checker_if.master av,
  output logic        accepted,
  output logic        data_valid,
  output logic        timed_out,
  output logic [31:0] data
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

  logic          rd_r;
  logic          addr_r;
  logic          pend_r;
  logic [1:0]    lat_r;
  logic [CW-1:0] cnt_r;

  assign av.av_read    = rd_r;
  assign av.av_address = addr_r;
  assign accepted      = rd_r && !av.av_waitrequest;
  assign data          = av.av_readdata;

  always_comb begin
    if (READ_LATENCY == 0) data_valid = accepted;
    else                   data_valid = pend_r && (lat_r == 2'(READ_LATENCY));
  end

  // A transaction that completes in its last allowed cycle is not a timeout.
  assign timed_out = (rd_r || pend_r) && !data_valid && (cnt_r == CW'(TIMEOUT_CYCLES));

  // NOTE: asynchronous reset drops av_read the instant reset rises, not at the next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_r   <= 1'b0;
      addr_r <= 1'b0;
      pend_r <= 1'b0;
      lat_r  <= '0;
      cnt_r  <= '0;
    end else if (launch) begin
      rd_r   <= 1'b1;
      addr_r <= launch_addr;
      pend_r <= 1'b0;
      lat_r  <= '0;
      cnt_r  <= '0;
    end else if (rd_r || pend_r) begin
      cnt_r <= cnt_r + CW'(1);
      if (timed_out) begin
        rd_r   <= 1'b0;
        pend_r <= 1'b0;
      end else if (accepted) begin
        rd_r   <= 1'b0;
        pend_r <= (READ_LATENCY != 0);
        lat_r  <= 2'd1;
      end else if (data_valid) begin
        pend_r <= 1'b0;
      end else if (pend_r) begin
        lat_r <= lat_r + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot gate: reads system ID and build timestamp, compares them with the expected
// values and holds the soft-CPU in reset until they match or bypass is asserted.
module sysid_boot_checker import sysid_pkg::*; #(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        bypass,
  sysid_boot_checker_if.master av,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_id,
  output logic        fail_ts,
  output logic        timeout,
  output logic [31:0] id_q,
  output logic [31:0] ts_q,
  output logic        cpu_reset
);

  state_t      state, next_state;
  logic        auto_r;
  logic        launch, launch_addr;
  logic        cap_id, cap_ts, do_cmp, do_timeout, do_clear;
  logic        accepted, data_valid, timed_out;
  logic [31:0] data;

  sysid_av_read_port #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_port (
    .clock      (clock),
    .reset      (reset),
    .launch     (launch),
    .launch_addr(launch_addr),
    .av         (av),
    .accepted   (accepted),
    .data_valid (data_valid),
    .timed_out  (timed_out),
    .data       (data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      auto_r <= 1'b1;
    end else begin
      state  <= next_state;
      auto_r <= 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    next_state  = state;
    launch      = 1'b0;
    launch_addr = ADDR_SYSID_ID;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    do_cmp      = 1'b0;
    do_timeout  = 1'b0;
    do_clear    = 1'b0;
    case (state)
      S_IDLE: begin
        if ((AUTO_START && auto_r) || start) begin
          launch     = 1'b1;
          next_state = S_RD_ID;
        end
      end
      S_RD_ID, S_WAIT_ID: begin
        if (data_valid) begin
          cap_id      = 1'b1;
          launch      = 1'b1;
          launch_addr = ADDR_SYSID_TS;
          next_state  = S_RD_TS;
        end else if (timed_out) begin
          do_timeout = 1'b1;
          next_state = S_DONE;
        end else if (state == S_RD_ID && accepted) begin
          next_state = S_WAIT_ID;
        end
      end
      S_RD_TS, S_WAIT_TS: begin
        if (data_valid) begin
          cap_ts     = 1'b1;
          next_state = S_CMP;
        end else if (timed_out) begin
          do_timeout = 1'b1;
          next_state = S_DONE;
        end else if (state == S_RD_TS && accepted) begin
          next_state = S_WAIT_TS;
        end
      end
      S_CMP: begin
        do_cmp     = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          do_clear   = 1'b1;
          launch     = 1'b1;
          next_state = S_RD_ID;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail_id <= 1'b0;
      fail_ts <= 1'b0;
      timeout <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      busy <= !(next_state inside {S_IDLE, S_DONE});
      if (cap_id) id_q <= data;
      if (cap_ts) ts_q <= data;
      if (do_clear) begin
        done    <= 1'b0;
        pass    <= 1'b0;
        fail_id <= 1'b0;
        fail_ts <= 1'b0;
        timeout <= 1'b0;
      end
      if (do_cmp) begin
        fail_id <= (id_q != EXPECTED_ID);
        fail_ts <= (ts_q != EXPECTED_TS);
        pass    <= (id_q == EXPECTED_ID) && ((ts_q == EXPECTED_TS) || !CHECK_TS);
        done    <= 1'b1;
      end
      if (do_timeout) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

  // Bypass is deliberately combinational so straps release the CPU without a clock.
  assign cpu_reset = !(pass || bypass);

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Bench for sysid_boot_checker: a zero-latency instance with timestamp checking and
// a two-cycle-latency instance with timestamp checking disabled, sharing clock and reset.
module tb_sysid_boot_checker;
  import sysid_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;

  // Instance 0: READ_LATENCY = 0, CHECK_TS = 1
  logic        start0 = 1'b0, bypass0 = 1'b0, wr0 = 1'b0;
  logic [31:0] mem0 [0:1];
  logic        busy0, done0, pass0, fail_id0, fail_ts0, timeout0, cpu_reset0;
  logic [31:0] id_q0, ts_q0;
  sysid_boot_checker_if bus0();
  assign bus0.av_waitrequest = wr0;
  assign bus0.av_readdata    = mem0[bus0.av_address];

  sysid_boot_checker #(.READ_LATENCY(0), .CHECK_TS(1'b1)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .bypass(bypass0), .av(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_id(fail_id0), .fail_ts(fail_ts0),
    .timeout(timeout0), .id_q(id_q0), .ts_q(ts_q0), .cpu_reset(cpu_reset0)
  );

  // Instance 1: READ_LATENCY = 2, CHECK_TS = 0; slave returns data two cycles after acceptance
  logic        start1 = 1'b0, bypass1 = 1'b0, wr1 = 1'b0;
  logic [31:0] mem1 [0:1];
  logic        busy1, done1, pass1, fail_id1, fail_ts1, timeout1, cpu_reset1;
  logic [31:0] id_q1, ts_q1;
  logic        p1 = 1'b0, p2 = 1'b0;
  sysid_boot_checker_if bus1();
  assign bus1.av_waitrequest = wr1;
  assign bus1.av_readdata    = mem1[p2];
  always @(posedge clock) begin
    if (bus1.av_read && !wr1) p1 <= bus1.av_address;
    p2 <= p1;
  end

  sysid_boot_checker #(.READ_LATENCY(2), .CHECK_TS(1'b0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .bypass(bypass1), .av(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_id(fail_id1), .fail_ts(fail_ts1),
    .timeout(timeout1), .id_q(id_q1), .ts_q(ts_q1), .cpu_reset(cpu_reset1)
  );

  typedef struct {
    logic [31:0] id_w;
    logic [31:0] ts_w;
    logic        exp_pass;
    logic        exp_fid;
    logic        exp_fts;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = which ? done1 : done0;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hDEADBEEE, 32'h5B92B311, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hDEADBEEF, 32'h5B92B311, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};

    mem0[0] = 32'hDEADBEEF; mem0[1] = 32'h5B92B311;
    mem1[0] = 32'hDEADBEEF; mem1[1] = 32'h5B92B311;

    // Reset state
    repeat (3) tick();
    check("rst done",      {31'd0, done0},      32'd0);
    check("rst pass",      {31'd0, pass0},      32'd0);
    check("rst busy",      {31'd0, busy0},      32'd0);
    check("rst av_read",   {31'd0, bus0.av_read}, 32'd0);
    check("rst cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    check("rst id_q",      id_q0,               32'd0);
    reset = 1'b0;

    // Auto start, zero latency: IDLE, RD_ID, RD_TS, CMP
    tick();
    check("e1 av_read",  {31'd0, bus0.av_read},    32'd1);
    check("e1 address",  {31'd0, bus0.av_address}, 32'd0);
    check("e1 busy",     {31'd0, busy0},           32'd1);
    tick();
    check("e2 av_read",  {31'd0, bus0.av_read},    32'd1);
    check("e2 address",  {31'd0, bus0.av_address}, 32'd1);
    tick();
    check("e3 av_read",  {31'd0, bus0.av_read},    32'd0);
    check("e3 done",     {31'd0, done0},           32'd0);
    tick();
    check("e4 done",      {31'd0, done0},      32'd1);
    check("e4 pass",      {31'd0, pass0},      32'd1);
    check("e4 cpu_reset", {31'd0, cpu_reset0}, 32'd0);
    check("e4 busy",      {31'd0, busy0},      32'd0);
    check("e4 id_q",      id_q0,               32'hDEADBEEF);
    check("e4 ts_q",      ts_q0,               32'h5B92B311);
    repeat (10) tick();

    // Table of recheck vectors on instance 0
    for (int v = 0; v < 4; v++) begin
      mem0[0] = vecs[v].id_w;
      mem0[1] = vecs[v].ts_w;
      pulse_start(1'b0);
      wait_done(1'b0, 20, $sformatf("vec%0d done", v));
      check($sformatf("vec%0d pass", v),      {31'd0, pass0},      {31'd0, vecs[v].exp_pass});
      check($sformatf("vec%0d fail_id", v),   {31'd0, fail_id0},   {31'd0, vecs[v].exp_fid});
      check($sformatf("vec%0d fail_ts", v),   {31'd0, fail_ts0},   {31'd0, vecs[v].exp_fts});
      check($sformatf("vec%0d cpu_reset", v), {31'd0, cpu_reset0}, {31'd0, !vecs[v].exp_pass});
      check($sformatf("vec%0d id_q", v),      id_q0,               vecs[v].id_w);
      check($sformatf("vec%0d ts_q", v),      ts_q0,               vecs[v].ts_w);
    end

    // Bad ID then bypass
    mem0[0] = 32'hDEADBEEE; mem0[1] = 32'h5B92B311;
    pulse_start(1'b0);
    wait_done(1'b0, 20, "byp done");
    check("byp fail_id pre", {31'd0, fail_id0},   32'd1);
    check("byp cpu_reset 1", {31'd0, cpu_reset0}, 32'd1);
    bypass0 = 1'b1;
    #1;
    check("byp cpu_reset 0", {31'd0, cpu_reset0}, 32'd0);
    tick();
    check("byp fail_id",     {31'd0, fail_id0},   32'd1);
    check("byp pass",        {31'd0, pass0},      32'd0);
    check("byp done",        {31'd0, done0},      32'd1);
    bypass0 = 1'b0;
    #1;
    check("byp released",    {31'd0, cpu_reset0}, 32'd1);

    // CHECK_TS = 0 instance: timestamp mismatch reported but pass holds
    mem1[0] = 32'hDEADBEEF; mem1[1] = 32'h00000000;
    pulse_start(1'b1);
    wait_done(1'b1, 30, "nts done");
    check("nts fail_ts",   {31'd0, fail_ts1},   32'd1);
    check("nts pass",      {31'd0, pass1},      32'd1);
    check("nts cpu_reset", {31'd0, cpu_reset1}, 32'd0);
    mem1[0] = 32'h0BADF00D; mem1[1] = 32'h5B92B311;
    pulse_start(1'b1);
    wait_done(1'b1, 30, "lid done");
    check("lid fail_id", {31'd0, fail_id1}, 32'd1);
    check("lid pass",    {31'd0, pass1},    32'd0);
    check("lid id_q",    id_q1,             32'h0BADF00D);

    // Timeout: waitrequest stuck high
    mem0[0] = 32'hDEADBEEF; mem0[1] = 32'h5B92B311;
    wr0 = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, 300, "to done");
    check("to timeout", {31'd0, timeout0},      32'd1);
    check("to av_read", {31'd0, bus0.av_read},  32'd0);
    check("to pass",    {31'd0, pass0},         32'd0);
    check("to busy",    {31'd0, busy0},         32'd0);
    repeat (40) tick();
    check("to held",    {31'd0, timeout0},      32'd1);
    wr0 = 1'b0;
    pulse_start(1'b0);
    check("to cleared", {31'd0, timeout0},      32'd0);
    wait_done(1'b0, 20, "to redo done");
    check("to redo pass",    {31'd0, pass0},    32'd1);
    check("to redo timeout", {31'd0, timeout0}, 32'd0);

    // Latency 2 with three wait states on the ID read, stray start while busy
    mem1[0] = 32'hDEADBEEF; mem1[1] = 32'h5B92B311;
    wr1 = 1'b1;
    pulse_start(1'b1);
    check("lat c1 av_read", {31'd0, bus1.av_read},    32'd1);
    check("lat c1 address", {31'd0, bus1.av_address}, 32'd0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("lat c2 av_read", {31'd0, bus1.av_read},    32'd1);
    tick();
    check("lat c3 av_read", {31'd0, bus1.av_read},    32'd1);
    check("lat c3 address", {31'd0, bus1.av_address}, 32'd0);
    wr1 = 1'b0;
    tick();
    check("lat a0 av_read", {31'd0, bus1.av_read}, 32'd0);
    check("lat a0 id_q",    id_q1,                 32'h0BADF00D);
    tick();
    check("lat a1 av_read", {31'd0, bus1.av_read}, 32'd0);
    check("lat a1 id_q",    id_q1,                 32'h0BADF00D);
    tick();
    check("lat a2 id_q",    id_q1,                    32'hDEADBEEF);
    check("lat a2 av_read", {31'd0, bus1.av_read},    32'd1);
    check("lat a2 address", {31'd0, bus1.av_address}, 32'd1);
    wait_done(1'b1, 20, "lat done");
    check("lat pass", {31'd0, pass1}, 32'd1);
    repeat (3) tick();
    check("lat no requeue done", {31'd0, done1}, 32'd1);
    check("lat no requeue busy", {31'd0, busy1}, 32'd0);

    // Asynchronous reset while in RD_TS
    pulse_start(1'b0);
    tick();
    check("mid av_read", {31'd0, bus0.av_read},    32'd1);
    check("mid address", {31'd0, bus0.av_address}, 32'd1);
    check("mid busy",    {31'd0, busy0},           32'd1);
    check("mid id_q",    id_q0,                    32'hDEADBEEF);
    reset = 1'b1;
    #1;
    check("ar av_read",   {31'd0, bus0.av_read}, 32'd0);
    check("ar busy",      {31'd0, busy0},        32'd0);
    check("ar done",      {31'd0, done0},        32'd0);
    check("ar pass",      {31'd0, pass0},        32'd0);
    check("ar cpu_reset", {31'd0, cpu_reset0},   32'd1);
    check("ar id_q",      id_q0,                 32'd0);
    tick();
    reset = 1'b0;
    wait_done(1'b0, 10, "ar rerun done");
    check("ar rerun pass",      {31'd0, pass0},      32'd1);
    check("ar rerun cpu_reset", {31'd0, cpu_reset0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
